// File: rtl/move_tiros_gen.sv
// move_tiros_gen: sweeps every shot slot once per request, moves loaded
// shots by STEP along their direction and unloads shots that would leave
// the screen. The shot memory is read combinationally at tiro_addr.
module move_tiros_gen #(
    parameter int N_TIROS = 8,
    parameter int COORD_W = 10,
    parameter int STEP    = 4,
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    localparam int IDX_W  = $clog2(N_TIROS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               movimenta_tiro,
    output logic [IDX_W-1:0]   tiro_addr,
    input  logic [COORD_W-1:0] tiro_x,
    input  logic [COORD_W-1:0] tiro_y,
    input  logic [2:0]         tiro_opcode,
    input  logic               tiro_loaded,
    output logic [COORD_W-1:0] new_x,
    output logic [COORD_W-1:0] new_y,
    output logic               we_pos,
    output logic               we_loaded,
    output logic               new_loaded,
    output logic               busy,
    output logic               movimentacao_concluida_tiro,
    output logic [IDX_W:0]     n_ativos,
    output logic [IDX_W:0]     n_expirados,
    output logic [3:0]         db_estado
);

    typedef enum logic [3:0] {
        INICIO         = 4'd0,
        ESPERA         = 4'd1,
        LE             = 4'd2,
        AVALIA         = 4'd3,
        ESCREVE_POS    = 4'd4,
        ESCREVE_LOADED = 4'd5,
        PROXIMO        = 4'd6,
        SINALIZA       = 4'd7
    } state_t;

    // One extra bit keeps sums and differences from wrapping before the
    // bound comparison.
    localparam logic [COORD_W:0] STEP_E  = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0] X_MAX_E = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0] Y_MAX_E = (COORD_W+1)'(Y_MAX);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_TIROS - 1);

    state_t             state, state_next;
    logic [COORD_W-1:0] reg_x, reg_y;
    logic [2:0]         reg_op;
    logic               reg_loaded;

    logic               x_move, x_dec, y_move, y_dec;
    logic [COORD_W:0]   x_ext, y_ext, x_sum, y_sum;
    logic               x_exit, y_exit, exits;
    logic [COORD_W-1:0] moved_x, moved_y;
    logic               is_last;

    // Decode the registered direction and compute the moved position and exit flag.
    always_comb begin
        x_move  = reg_op[2] | ~reg_op[1];
        x_dec   = reg_op[2] ? reg_op[1] : reg_op[0];
        y_move  = reg_op[2] | reg_op[1];
        y_dec   = reg_op[0];
        x_ext   = {1'b0, reg_x};
        y_ext   = {1'b0, reg_y};
        x_sum   = x_dec ? (x_ext - STEP_E) : (x_ext + STEP_E);
        y_sum   = y_dec ? (y_ext - STEP_E) : (y_ext + STEP_E);
        x_exit  = x_move & (x_dec ? (x_ext < STEP_E) : (x_sum > X_MAX_E));
        y_exit  = y_move & (y_dec ? (y_ext < STEP_E) : (y_sum > Y_MAX_E));
        exits   = x_exit | y_exit;
        moved_x = x_move ? x_sum[COORD_W-1:0] : reg_x;
        moved_y = y_move ? y_sum[COORD_W-1:0] : reg_y;
        is_last = (tiro_addr == LAST);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INICIO;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_next; without it a
        // missed branch would infer a latch.
        state_next = state;
        case (state)
            INICIO:   state_next = ESPERA;
            ESPERA:   if (movimenta_tiro) state_next = LE;
            LE:       state_next = AVALIA;
            AVALIA: begin
                if (!reg_loaded) state_next = is_last ? SINALIZA : PROXIMO;
                else if (exits)  state_next = ESCREVE_LOADED;
                else             state_next = ESCREVE_POS;
            end
            ESCREVE_POS, ESCREVE_LOADED:
                      state_next = is_last ? SINALIZA : PROXIMO;
            PROXIMO:  state_next = LE;
            SINALIZA: state_next = ESPERA;
            default:  state_next = INICIO;
        endcase
    end

    // Slot address, registered slot data and per-sweep counters.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: only these few control and data registers need a reset; the
        // shot memory itself lives outside this block and is not cleared here.
        if (reset) begin
            tiro_addr   <= '0;
            reg_x       <= '0;
            reg_y       <= '0;
            reg_op      <= '0;
            reg_loaded  <= 1'b0;
            n_ativos    <= '0;
            n_expirados <= '0;
        end else begin
            if (state == ESPERA && movimenta_tiro) begin
                tiro_addr   <= '0;
                n_ativos    <= '0;
                n_expirados <= '0;
            end
            if (state == PROXIMO) tiro_addr <= tiro_addr + IDX_W'(1);
            if (state == LE) begin
                reg_x      <= tiro_x;
                reg_y      <= tiro_y;
                reg_op     <= tiro_opcode;
                reg_loaded <= tiro_loaded;
            end
            if (state == AVALIA && state_next == ESCREVE_POS)
                n_ativos <= n_ativos + (IDX_W+1)'(1);
            if (state == AVALIA && state_next == ESCREVE_LOADED)
                n_expirados <= n_expirados + (IDX_W+1)'(1);
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        we_pos                      = (state == ESCREVE_POS);
        we_loaded                   = (state == ESCREVE_LOADED);
        new_loaded                  = (state == ESCREVE_POS);
        new_x                       = (state == ESCREVE_POS) ? moved_x : reg_x;
        new_y                       = (state == ESCREVE_POS) ? moved_y : reg_y;
        busy                        = (state != INICIO) && (state != ESPERA);
        movimentacao_concluida_tiro = (state == SINALIZA);
        db_estado                   = state;
    end

endmodule

// File: tb/tb_move_tiros_gen.sv
// Bench for move_tiros_gen: a shot memory model, a slot-level reference
// model of each sweep, a per-cycle compare process, directed and random sweeps.
module tb_move_tiros_gen;

    localparam int N    = 8;
    localparam int CW   = 10;
    localparam int STEP = 4;
    localparam int XM   = 639;
    localparam int YM   = 479;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          movimenta_tiro = 1'b0;
    logic [2:0]    tiro_addr;
    logic [CW-1:0] tiro_x, tiro_y, new_x, new_y;
    logic [2:0]    tiro_opcode;
    logic          tiro_loaded;
    logic          we_pos, we_loaded, new_loaded, busy, done;
    logic [3:0]    n_ativos, n_expirados, db_estado;

    move_tiros_gen #(.N_TIROS(N), .COORD_W(CW), .STEP(STEP), .X_MAX(XM), .Y_MAX(YM)) dut (
        .clock(clock), .reset(reset), .movimenta_tiro(movimenta_tiro),
        .tiro_addr(tiro_addr), .tiro_x(tiro_x), .tiro_y(tiro_y),
        .tiro_opcode(tiro_opcode), .tiro_loaded(tiro_loaded),
        .new_x(new_x), .new_y(new_y), .we_pos(we_pos), .we_loaded(we_loaded),
        .new_loaded(new_loaded), .busy(busy), .movimentacao_concluida_tiro(done),
        .n_ativos(n_ativos), .n_expirados(n_expirados), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Shot memory: combinational read, written by the DUT or by the host port.
    logic [CW-1:0] mem_x [N];
    logic [CW-1:0] mem_y [N];
    logic [2:0]    mem_op [N];
    logic          mem_loaded [N];
    logic          host_we = 1'b0;
    int            host_addr = 0;
    logic [CW-1:0] host_x = '0, host_y = '0;
    logic [2:0]    host_op = '0;
    logic          host_ld = 1'b0;

    assign tiro_x      = mem_x[tiro_addr];
    assign tiro_y      = mem_y[tiro_addr];
    assign tiro_opcode = mem_op[tiro_addr];
    assign tiro_loaded = mem_loaded[tiro_addr];

    always @(posedge clock) begin
        if (host_we) begin
            mem_x[host_addr]      <= host_x;
            mem_y[host_addr]      <= host_y;
            mem_op[host_addr]     <= host_op;
            mem_loaded[host_addr] <= host_ld;
        end else begin
            if (we_pos) begin
                mem_x[tiro_addr]      <= new_x;
                mem_y[tiro_addr]      <= new_y;
                mem_loaded[tiro_addr] <= new_loaded;
            end
            if (we_loaded) mem_loaded[tiro_addr] <= new_loaded;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected writes of one sweep with their cycle numbers.
    typedef struct {
        int cyc;
        int addr;
        bit is_pos;
        int x;
        int y;
    } wr_t;

    wr_t exp_q[$];
    int  exp_done, exp_act, exp_exp;
    int  cyc = 0;
    bit  sweep_active = 0;
    int  last_done = 0;
    int  done_count = 0;
    int  writes_seen = 0;

    task automatic direction(input logic [2:0] op, output int sx, output int sy);
        case (op)
            3'd0: begin sx =  1; sy =  0; end
            3'd1: begin sx = -1; sy =  0; end
            3'd2: begin sx =  0; sy =  1; end
            3'd3: begin sx =  0; sy = -1; end
            3'd4: begin sx =  1; sy =  1; end
            3'd5: begin sx =  1; sy = -1; end
            3'd6: begin sx = -1; sy =  1; end
            default: begin sx = -1; sy = -1; end
        endcase
    endtask

    task automatic plan_sweep();
        int  k, sx, sy, nx, ny;
        bit  gone;
        wr_t w;
        k = 0;
        exp_q.delete();
        exp_act = 0;
        exp_exp = 0;
        for (int i = 0; i < N; i++) begin
            if (mem_loaded[i]) begin
                direction(mem_op[i], sx, sy);
                nx = int'(mem_x[i]) + sx * STEP;
                ny = int'(mem_y[i]) + sy * STEP;
                gone = (sx != 0 && (nx < 0 || nx > XM)) || (sy != 0 && (ny < 0 || ny > YM));
                w.cyc    = 3 * i + k + 3;
                w.addr   = i;
                w.is_pos = !gone;
                w.x      = gone ? int'(mem_x[i]) : nx;
                w.y      = gone ? int'(mem_y[i]) : ny;
                exp_q.push_back(w);
                if (gone) exp_exp++; else exp_act++;
                k++;
            end
        end
        exp_done = 3 * N + k;
    endtask

    // Compare process: every cycle, against the planned sweep or the idle state.
    always @(negedge clock) begin
        wr_t w;
        if (sweep_active) begin
            cyc++;
            check("we_exclusive", 32'(we_pos & we_loaded), 0);
            if (we_pos || we_loaded) begin
                writes_seen++;
                check("write_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("wr_cycle", cyc, w.cyc);
                    check("wr_addr", 32'(tiro_addr), w.addr);
                    check("wr_is_pos", 32'(we_pos), 32'(w.is_pos));
                    check("wr_new_x", 32'(new_x), w.x);
                    check("wr_new_y", 32'(new_y), w.y);
                    check("wr_new_loaded", 32'(new_loaded), 32'(w.is_pos));
                end
            end
            if (done || cyc >= exp_done) begin
                check("done_cycle", cyc, exp_done);
                check("done_pulse", 32'(done), 1);
                check("writes_pending", exp_q.size(), 0);
                check("n_ativos", 32'(n_ativos), exp_act);
                check("n_expirados", 32'(n_expirados), exp_exp);
                if (done) done_count++;
                last_done = cyc;
                sweep_active = 0;
            end else begin
                check("busy_in_sweep", 32'(busy), 1);
            end
        end else begin
            if (we_pos || we_loaded || done) writes_seen++;
            if (done) done_count++;
            check("idle_quiet", {28'd0, we_pos, we_loaded, done, busy}, 0);
        end
    end

    task automatic load_slot(input int i, input int x, input int y, input int op, input bit ld);
        @(negedge clock);
        host_we = 1'b1; host_addr = i;
        host_x = CW'(x); host_y = CW'(y); host_op = 3'(op); host_ld = ld;
        @(negedge clock);
        host_we = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < N; i++) load_slot(i, 0, 0, 0, 1'b0);
    endtask

    task automatic start_sweep(input bit extra_pulse);
        @(negedge clock);
        plan_sweep();
        movimenta_tiro = 1'b1;
        @(posedge clock);
        cyc = 0;
        sweep_active = 1;
        @(negedge clock);
        movimenta_tiro = 1'b0;
        if (extra_pulse) begin
            repeat (4) @(negedge clock);
            movimenta_tiro = 1'b1;
            @(negedge clock);
            movimenta_tiro = 1'b0;
        end
    endtask

    task automatic run_sweep(input bit extra_pulse);
        start_sweep(extra_pulse);
        for (int t = 0; t < 200 && sweep_active; t++) @(negedge clock);
        check("sweep_finished", 32'(sweep_active), 0);
        sweep_active = 0;
        repeat (3) @(negedge clock);
        check("n_ativos_held", 32'(n_ativos), exp_act);
        check("n_expirados_held", 32'(n_expirados), exp_exp);
    endtask

    function automatic int rand_coord(input int mx);
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 7);
            1:       return mx - $urandom_range(0, 7);
            default: return $urandom_range(0, mx);
        endcase
    endfunction

    initial begin
        int dc, ws, t;
        for (int i = 0; i < N; i++) begin
            mem_x[i] = '0; mem_y[i] = '0; mem_op[i] = '0; mem_loaded[i] = 1'b0;
        end
        repeat (3) @(negedge clock);
        check("rst_db_estado", 32'(db_estado), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_we", 32'({we_pos, we_loaded}), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(tiro_addr), 0);
        check("rst_counts", 32'({n_ativos, n_expirados}), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_state", 32'(db_estado), 1);

        // All slots empty: no writes, done in cycle 24.
        clear_mem();
        ws = writes_seen;
        run_sweep(1'b0);
        check("t1_done_cycle", last_done, 24);
        check("t1_writes", writes_seen - ws, 0);
        check("t1_n_ativos", 32'(n_ativos), 0);

        // Slot 2 moves +x from (100,100).
        load_slot(2, 100, 100, 0, 1'b1);
        run_sweep(1'b0);
        check("t2_x", 32'(mem_x[2]), 104);
        check("t2_y", 32'(mem_y[2]), 100);
        check("t2_done_cycle", last_done, 25);
        check("t2_n_ativos", 32'(n_ativos), 1);

        // Slot 0 diagonal +x+y: exits at x=637, moves at x=635.
        clear_mem();
        load_slot(0, 637, 50, 4, 1'b1);
        run_sweep(1'b0);
        check("t3_unloaded", 32'(mem_loaded[0]), 0);
        check("t3_n_expirados", 32'(n_expirados), 1);
        load_slot(0, 635, 50, 4, 1'b1);
        run_sweep(1'b0);
        check("t3_x", 32'(mem_x[0]), 639);
        check("t3_y", 32'(mem_y[0]), 54);
        check("t3_loaded", 32'(mem_loaded[0]), 1);

        // Last slot expires going -y from y=3; exactly one done pulse.
        clear_mem();
        load_slot(7, 20, 3, 3, 1'b1);
        dc = done_count;
        run_sweep(1'b0);
        check("t4_unloaded", 32'(mem_loaded[7]), 0);
        check("t4_done_cycle", last_done, 25);
        check("t4_done_once", done_count - dc, 1);
        check("t4_n_expirados", 32'(n_expirados), 1);

        // Second start pulse mid-sweep is ignored.
        load_slot(1, 300, 200, 6, 1'b1);
        dc = done_count;
        run_sweep(1'b1);
        repeat (30) @(negedge clock);
        check("t5_done_once", done_count - dc, 1);
        check("t5_x", 32'(mem_x[1]), 296);
        check("t5_y", 32'(mem_y[1]), 204);

        // Reset while writing: sweep abandoned, write dropped, no done pulse.
        clear_mem();
        load_slot(3, 100, 200, 2, 1'b1);
        dc = done_count;
        start_sweep(1'b0);
        for (t = 0; t < 60 && !we_pos; t++) @(negedge clock);
        check("t6_reached_write", 32'(we_pos), 1);
        #2;
        reset = 1'b1;
        sweep_active = 0;
        exp_q.delete();
        #1;
        check("t6_state", 32'(db_estado), 0);
        check("t6_we_pos", 32'(we_pos), 0);
        check("t6_busy", 32'(busy), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("t6_no_done", done_count - dc, 0);
        check("t6_y_unchanged", 32'(mem_y[3]), 200);

        // Random sweeps against the reference model.
        for (int s = 0; s < 20; s++) begin
            for (int i = 0; i < N; i++)
                load_slot(i, rand_coord(XM), rand_coord(YM), $urandom_range(0, 7),
                          1'($urandom_range(0, 2) != 0));
            run_sweep(1'($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
